// File: rtl/adder_share_sched.sv
// Round-robin scheduler sharing one start/valid adder among NREQ requesters.
// One transaction in flight (IDLE -> ISSUE -> WAIT -> RESP) with timeout and protocol fault flags.
module adder_share_sched #(
    parameter int W       = 8,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [W-1:0]      rsp_y,
    output logic              rsp_err,
    output logic              add_start,
    output logic [W-1:0]      add_a,
    output logic [W-1:0]      add_b,
    input  logic [W-1:0]      add_y,
    input  logic              add_valid,
    output logic [1:0]        err_flags
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [W-1:0]    rsp_y_q, rsp_y_d;
    logic            rsp_err_q, rsp_err_d;
    logic            add_start_q, add_start_d;
    logic [W-1:0]    add_a_q, add_a_d;
    logic [W-1:0]    add_b_q, add_b_d;
    logic [1:0]      err_flags_q, err_flags_d;

    logic            found;
    logic [PW-1:0]   win_idx;
    logic [W-1:0]    win_a;
    logic [W-1:0]    win_b;

    // Search ptr+1, ptr+2, ... (mod NREQ); first set request wins.
    always_comb begin
        int unsigned     cand;
        logic [NREQ-1:0] req_rot;
        found   = 1'b0;
        win_idx = ptr_q;
        cand    = 0;
        req_rot = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand    = ({{(32-PW){1'b0}}, ptr_q} + i) % NREQ;
            req_rot = req >> cand;
            if (!found && req_rot[0]) begin
                found   = 1'b1;
                win_idx = cand[PW-1:0];
            end
        end
        win_a = W'(req_a >> (win_idx * W));
        win_b = W'(req_b >> (win_idx * W));
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        wait_cnt_d  = wait_cnt_q;
        gnt_d       = '0;
        rsp_valid_d = '0;
        rsp_y_d     = '0;
        rsp_err_d   = 1'b0;
        add_start_d = 1'b0;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        err_flags_d = err_flags_q;

        if (add_valid && state_q != S_WAIT) begin
            err_flags_d[1] = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    add_a_d     = win_a;
                    add_b_d     = win_b;
                    ptr_d       = win_idx;
                    gnt_d       = NREQ'(1) << win_idx;
                    add_start_d = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (add_valid) begin
                    rsp_valid_d = NREQ'(1) << ptr_q;
                    rsp_y_d     = add_y;
                    state_d     = S_RESP;
                end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
                    err_flags_d[0] = 1'b1;
                    rsp_valid_d    = NREQ'(1) << ptr_q;
                    rsp_err_d      = 1'b1;
                    state_d        = S_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= PW'(NREQ - 1);
            wait_cnt_q  <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_y_q     <= '0;
            rsp_err_q   <= 1'b0;
            add_start_q <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            err_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            wait_cnt_q  <= wait_cnt_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_y_q     <= rsp_y_d;
            rsp_err_q   <= rsp_err_d;
            add_start_q <= add_start_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            err_flags_q <= err_flags_d;
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_err   = rsp_err_q;
    assign add_start = add_start_q;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign err_flags = err_flags_q;

endmodule

// File: tb/tb_adder_share_sched.sv
// Bench for adder_share_sched: vector table, hand-written corner sequences and
// randomized transactions against a round-robin/sum reference model.
module tb_adder_share_sched;
    localparam int W       = 8;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*W-1:0] req_a = '0;
    logic [NREQ*W-1:0] req_b = '0;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_y;
    logic              rsp_err;
    logic              add_start;
    logic [W-1:0]      add_a;
    logic [W-1:0]      add_b;
    logic [W-1:0]      add_y;
    logic              add_valid;
    logic [1:0]        err_flags;

    logic       av_q = 1'b0;
    logic [W-1:0] ay_q = '0;
    logic       adder_dead = 1'b0;
    logic       spur = 1'b0;

    int         total = 0;
    int         bad = 0;
    int         ptr_m = NREQ - 1;
    logic [1:0] exp_ef = 2'b00;

    adder_share_sched #(
        .W(W),
        .NREQ(NREQ),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .req_a(req_a),
        .req_b(req_b),
        .gnt(gnt),
        .rsp_valid(rsp_valid),
        .rsp_y(rsp_y),
        .rsp_err(rsp_err),
        .add_start(add_start),
        .add_a(add_a),
        .add_b(add_b),
        .add_y(add_y),
        .add_valid(add_valid),
        .err_flags(err_flags)
    );

    always #5 clk = ~clk;

    // Adder with 1-cycle start->valid latency; can be silenced or made to fire spuriously.
    always @(posedge clk) begin
        av_q <= add_start && !adder_dead;
        ay_q <= add_a + add_b;
    end
    assign add_valid = av_q | spur;
    assign add_y     = ay_q;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] rq, input int p);
        for (int i = 1; i <= NREQ; i++) begin
            int c;
            c = (p + i) % NREQ;
            if (rq[c]) return c;
        end
        return -1;
    endfunction

    // Starts in an IDLE cycle; ends in the IDLE cycle after the response.
    task automatic do_txn(input logic [3:0] rq, input logic [31:0] a, input logic [31:0] b,
                          input int win, input logic [7:0] ey, input bit dead);
        logic [3:0] eg;
        int         lat;
        int         exp_lat;
        eg         = 4'b0001 << win;
        adder_dead = dead;
        req        = rq;
        req_a      = a;
        req_b      = b;
        tick();
        chk("gnt", 32'(gnt), 32'(eg));
        chk("add_start", 32'(add_start), 32'd1);
        chk("add_a", 32'(add_a), 32'(8'(a >> (win * 8))));
        chk("add_b", 32'(add_b), 32'(8'(b >> (win * 8))));
        req     = rq & ~eg;
        lat     = 0;
        exp_lat = dead ? TIMEOUT + 1 : 2;
        for (int n = 1; n <= TIMEOUT + 4; n++) begin
            tick();
            if (rsp_valid != '0) begin
                lat = n;
                break;
            end
        end
        chk("rsp_latency", 32'(lat), 32'(exp_lat));
        chk("rsp_valid", 32'(rsp_valid), 32'(eg));
        chk("rsp_y", 32'(rsp_y), dead ? 32'd0 : 32'(ey));
        chk("rsp_err", 32'(rsp_err), 32'(dead));
        if (dead) exp_ef[0] = 1'b1;
        tick();
        chk("rsp_idle", 32'({rsp_valid, rsp_y, rsp_err, gnt}), 32'd0);
        chk("err_flags", 32'(err_flags), 32'(exp_ef));
        req        = '0;
        adder_dead = 1'b0;
        ptr_m      = win;
    endtask

    typedef struct {
        logic [3:0]  rq;
        logic [31:0] a;
        logic [31:0] b;
        int          win;
        logic [7:0]  y;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{4'b1111, 32'h40302010, 32'h04030201, 0, 8'h11};
        vecs[1] = '{4'b1110, 32'h40302010, 32'h04030201, 1, 8'h22};
        vecs[2] = '{4'b1100, 32'h40302010, 32'h04030201, 2, 8'h33};
        vecs[3] = '{4'b1000, 32'h40302010, 32'h04030201, 3, 8'h44};
        vecs[4] = '{4'b0100, 32'h00120000, 32'h00340000, 2, 8'h46};
        vecs[5] = '{4'b0010, 32'h0000F000, 32'h00002000, 1, 8'h10};
        vecs[6] = '{4'b1001, 32'hFF0000AA, 32'h01000055, 3, 8'h00};
        vecs[7] = '{4'b1001, 32'hFF0000AA, 32'h01000055, 0, 8'hFF};
        vecs[8] = '{4'b0110, 32'h00807F00, 32'h00018100, 1, 8'h00};
        vecs[9] = '{4'b0110, 32'h00807F00, 32'h00018100, 2, 8'h81};

        rst = 1'b1;
        repeat (2) tick();
        chk("reset_gnt_rsp", 32'({gnt, rsp_valid, rsp_err, add_start}), 32'd0);
        chk("reset_rsp_y", 32'(rsp_y), 32'd0);
        chk("reset_add_ops", 32'({add_a, add_b}), 32'd0);
        chk("reset_err_flags", 32'(err_flags), 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            do_txn(vecs[i].rq, vecs[i].a, vecs[i].b, vecs[i].win, vecs[i].y, 1'b0);
        end

        // Timeout abort, then normal service with the sticky flag retained.
        do_txn(4'b0001, 32'h00000077, 32'h00000011, rr_pick(4'b0001, ptr_m), 8'h00, 1'b1);
        chk("timeout_flag", 32'(err_flags), 32'd1);
        do_txn(4'b0001, 32'h00000077, 32'h00000011, rr_pick(4'b0001, ptr_m), 8'h88, 1'b0);
        chk("timeout_flag_sticky", 32'(err_flags), 32'd1);

        // Spurious add_valid while idle.
        spur = 1'b1;
        tick();
        spur = 1'b0;
        exp_ef[1] = 1'b1;
        chk("spurious_flag", 32'(err_flags), 32'd3);
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("spurious_no_rsp", 32'({rsp_valid, gnt, add_start}), 32'd0);
        end
        do_txn(4'b1000, 32'h05000000, 32'h06000000, rr_pick(4'b1000, ptr_m), 8'h0B, 1'b0);

        for (int t = 0; t < 24; t++) begin
            int          g;
            int          w;
            logic [3:0]  rq;
            logic [31:0] a;
            logic [31:0] b;
            logic [7:0]  y;
            bit          dd;
            g = $urandom_range(0, 2);
            repeat (g) tick();
            if ($urandom_range(0, 7) == 0) begin
                spur = 1'b1;
                tick();
                spur = 1'b0;
                exp_ef[1] = 1'b1;
            end
            rq = 4'($urandom_range(1, 15));
            a  = $urandom;
            b  = $urandom;
            dd = ($urandom_range(0, 5) == 0);
            w  = rr_pick(rq, ptr_m);
            y  = 8'(a >> (w * 8)) + 8'(b >> (w * 8));
            do_txn(rq, a, b, w, y, dd);
        end

        // Reset while waiting on the adder discards the transaction.
        req   = 4'b0010;
        req_a = 32'h00003300;
        req_b = 32'h00004400;
        tick();
        req = '0;
        tick();
        rst = 1'b1;
        tick();
        chk("rst_wait_ctrl", 32'({gnt, rsp_valid, rsp_err, add_start, err_flags}), 32'd0);
        chk("rst_wait_data", 32'({rsp_y, add_a, add_b}), 32'd0);
        rst    = 1'b0;
        exp_ef = 2'b00;
        ptr_m  = NREQ - 1;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("rst_wait_no_rsp", 32'({rsp_valid, gnt}), 32'd0);
        end
        do_txn(4'b1001, 32'h01000002, 32'h01000003, 0, 8'h05, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
